// File: rtl/mv_tile_engine.sv
// mv_tile_engine: tiled signed matrix-vector engine.
// Rows are processed PE_NUM at a time. Each tile streams one column per cycle
// from the x/w memories into PE_NUM accumulators. The tile's results are then
// drained through a ready/valid port after an arithmetic shift, an optional
// ReLU and saturation to DATA_W.
module mv_tile_engine #(
    parameter int PE_NUM = 20,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIM_W-1:0]          rows,
    input  logic [DIM_W-1:0]          cols,
    input  logic [4:0]                shift,
    input  logic                      relu_en,
    output logic                      busy,
    output logic                      done,
    output logic                      x_en,
    output logic [DIM_W-1:0]          x_addr,
    input  logic signed [DATA_W-1:0]  x_data,
    output logic                      w_en,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic [PE_NUM*DATA_W-1:0]  w_data,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic signed [DATA_W-1:0]  y_data,
    output logic [DIM_W-1:0]          y_idx
);

    localparam int LANE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    state_t                   state;
    logic [DIM_W-1:0]         rows_q;
    logic [DIM_W-1:0]         cols_q;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic [LANE_W-1:0]        lane;
    logic [LANE_W-1:0]        lane_inc;
    logic [DIM_W-1:0]         row;
    logic [DIM_W:0]           row_inc;
    logic                     vld_p1;
    logic                     hs;
    logic                     more_rows;
    logic                     last_lane;
    logic                     cmd_go;
    logic                     tile_next;
    logic                     acc_clr;

    logic signed [DATA_W-1:0]   w_lane  [PE_NUM];
    logic signed [2*DATA_W-1:0] prod    [PE_NUM];
    logic signed [ACC_W-1:0]    acc     [PE_NUM];
    logic signed [ACC_W-1:0]    acc_nxt [PE_NUM];

    // Arithmetic right shift followed by the optional clamp of negatives to zero.
    function automatic logic signed [ACC_W-1:0] shift_relu(
        input logic signed [ACC_W-1:0] a,
        input logic [4:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> sh;
        if (relu && s[ACC_W-1])
            s = '0;
        return s;
    endfunction

    // Clamp an accumulator-width value into the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] saturate(
        input logic signed [ACC_W-1:0] s
    );
        if (s > SAT_MAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (s < SAT_MIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return s[DATA_W-1:0];
    endfunction

    assign hs        = y_valid && y_ready;
    assign lane_inc  = lane + 1'b1;
    assign row_inc   = {1'b0, row} + 1'b1;
    assign more_rows = row_inc < {1'b0, rows_q};
    assign last_lane = (lane == LANE_W'(PE_NUM - 1)) || !more_rows;
    assign cmd_go    = (state == IDLE) && start && (rows != '0) && (cols != '0);
    assign tile_next = (state == DRAIN) && hs && last_lane && more_rows;
    assign acc_clr   = cmd_go || tile_next;

    // Per-lane full-precision product and the accumulator value it produces.
    always_comb begin
        for (int p = 0; p < PE_NUM; p++) begin
            w_lane[p]  = w_data[p*DATA_W +: DATA_W];
            prod[p]    = (2*DATA_W)'(x_data) * (2*DATA_W)'(w_lane[p]);
            acc_nxt[p] = vld_p1 ? acc[p] + ACC_W'(prod[p]) : acc[p];
        end
    end

    // Read-data valid: memory data arrives one cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= x_en;
    end

    // Accumulators: cleared at the start of every tile, otherwise take the MAC result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PE_NUM; p++)
                acc[p] <= '0;
        end else if (acc_clr) begin
            for (int p = 0; p < PE_NUM; p++)
                acc[p] <= '0;
        end else begin
            for (int p = 0; p < PE_NUM; p++)
                acc[p] <= acc_nxt[p];
        end
    end

    // Command sequencer: tile load, pipeline flush, result drain, completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            lane    <= '0;
            row     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_en    <= 1'b0;
            w_en    <= 1'b0;
            x_addr  <= '0;
            w_addr  <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q  <= rows;
                        cols_q  <= cols;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        lane    <= '0;
                        row     <= '0;
                        if (cmd_go) begin
                            state  <= LOAD;
                            busy   <= 1'b1;
                            x_en   <= 1'b1;
                            w_en   <= 1'b1;
                            x_addr <= '0;
                            w_addr <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Weight addresses are contiguous across tiles (tile*cols+col),
                    // so w_addr simply keeps counting.
                    if (x_addr == cols_q - 1'b1) begin
                        x_en  <= 1'b0;
                        w_en  <= 1'b0;
                        state <= FLUSH;
                    end else begin
                        x_addr <= x_addr + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                FLUSH: begin
                    // Lane 0 result includes the final product landing this cycle.
                    state   <= DRAIN;
                    y_valid <= 1'b1;
                    y_idx   <= row;
                    y_data  <= saturate(shift_relu(acc_nxt[0], shift_q, relu_q));
                end
                DRAIN: begin
                    if (hs) begin
                        if (!last_lane) begin
                            lane   <= lane_inc;
                            row    <= row_inc[DIM_W-1:0];
                            y_idx  <= row_inc[DIM_W-1:0];
                            y_data <= saturate(shift_relu(acc[lane_inc], shift_q, relu_q));
                        end else if (more_rows) begin
                            y_valid <= 1'b0;
                            lane    <= '0;
                            row     <= row_inc[DIM_W-1:0];
                            state   <= LOAD;
                            x_en    <= 1'b1;
                            w_en    <= 1'b1;
                            x_addr  <= '0;
                            w_addr  <= w_addr + 1'b1;
                        end else begin
                            y_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
